gray_seq_gen: RTL
=================

# gray_seq_gen

Sequential source stage that produces a bounded stream of Gray-coded words on a valid/ready interface, sitting directly upstream of Gray-code consumers (pointer comparators, position encoders) in the same datapath as the combinational binary-to-Gray converter. It holds a binary counter internally, converts it to Gray on a registered output, and advances only on accepted transfers. A run is launched by a start pulse with a seed, a length and a direction, and ends with a one-cycle done pulse.

## Interface

- VEC_W, 4, width of the binary counter and Gray output (≥2)
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- start_i  input  1  launch-run pulse, sampled only in IDLE
- seed_i  input  VEC_W  binary value of first emitted code
- len_i  input  VEC_W+1  number of codes in run, 0..2^VEC_W
- dir_i  input  1  1 = count up, 0 = count down
- ready_i  input  1  downstream accepts gray_o this cycle
- valid_o  output  1  gray_o holds a valid code
- gray_o  output  VEC_W  registered Gray code, bin ^ (bin >> 1)
- last_o  output  1  current beat is final beat of run (qualified by valid_o)
- busy_o  output  1  run in progress (RUN state)
- done_o  output  1  one-cycle pulse after final beat accepted

## Operation

- States: IDLE, RUN, DONE.
- IDLE: valid_o=0, busy_o=0. On start_i=1: latch len_i, dir_i; bin <= seed_i; remaining <= len_i. If len_i=0 go DONE; else go RUN.
- RUN: valid_o=1, busy_o=1, gray_o = Gray(bin) registered. On valid_o & ready_i: if remaining=1 go DONE; else bin <= bin ± 1 (dir), remaining <= remaining − 1.
- Stall: while ready_i=0, gray_o, last_o, bin, remaining hold stable; valid_o stays 1 (no retraction).
- last_o = 1 in RUN when remaining = 1.
- DONE: done_o=1, valid_o=0, busy_o=0; unconditionally return to IDLE next cycle.
- Arithmetic: bin is modulo 2^VEC_W; up from all-ones wraps to 0, down from 0 wraps to all-ones; consecutive emitted codes always differ in exactly one bit, including across wrap.
- len_i = 2^VEC_W emits every code once; remaining is VEC_W+1 bits.
- start_i outside IDLE ignored; seed_i/len_i/dir_i changes mid-run have no effect.
- gray_o in IDLE/DONE holds last value (don't-care to consumers; not X).

## Timing

- Reset (async assert, sync-to-clk release expected externally): state=IDLE, bin=0, remaining=0, gray_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0. Reset mid-run aborts with no done_o.
- start_i at edge t (IDLE) -> valid_o=1 and gray_o=Gray(seed_i) visible after edge t, i.e. cycle t+1. Latency 1 cycle.
- With ready_i held 1: one code per cycle; N-code run occupies N RUN cycles, done_o in cycle t+N+1, IDLE again at t+N+2; earliest next start accepted at edge t+N+2.
- len_i=0: done_o in cycle t+1, no valid beat.
- All outputs registered; no combinational path from ready_i to any output.

## Test plan

- Reset: assert reset_n=0 mid-run (after 3 beats) -> all outputs 0 immediately, no done_o; after release start_i works normally.
- Full up sweep, VEC_W=4, seed=0, len=16, dir=1, ready=1 -> gray_o 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8; last_o only with 8; done_o one cycle after.
- Down wrap: seed=1, len=4, dir=0 -> gray_o 1,0,8,9 (bin 1,0,F,E); each pair differs in one bit.
- Backpressure: seed=5, len=3, ready toggling 1,0,0,1,0,1 -> accepted sequence 7,5,4 exactly once each; gray_o/last_o stable during stalls.
- len=0 and ignored start: start with len=0 -> done_o next cycle, valid_o never 1; start_i pulsed during RUN -> run length and codes unchanged.
- Back-to-back runs: start on the first IDLE cycle after done_o, seed=E, len=2, dir=1 -> gray_o 9,8, last_o on 8.

Source files
------------

// File: rtl/gray_seq_gen.sv
// gray_seq_gen: bounded Gray-code source on a valid/ready interface.
// A binary counter advances on each accepted beat. Its Gray encoding is
// presented on a registered output, and a run ends with a one-cycle done pulse.
module gray_seq_gen #(
  parameter int VEC_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [VEC_W-1:0] seed_i,
  input  logic [VEC_W:0]   len_i,
  input  logic             dir_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [VEC_W-1:0] gray_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [VEC_W:0] REM_ONE = (VEC_W+1)'(1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] bin_q, bin_d;
  logic [VEC_W:0]   rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [VEC_W-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [VEC_W-1:0] bin_step;
  logic [VEC_W:0]   rem_dec;

  function automatic logic [VEC_W-1:0] to_gray(input logic [VEC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Next counter value and remaining count for an accepted beat.
  // The counter wraps modulo 2^VEC_W in both directions.
  always_comb begin
    bin_step = dir_q ? (bin_q + VEC_W'(1)) : (bin_q - VEC_W'(1));
    rem_dec  = rem_q - REM_ONE;
  end

  // Next-state and next-output logic.
  // All outputs come from flops, so ready_i never reaches a port combinationally.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    gray_d  = gray_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
        if (start_i) begin
          dir_d = dir_i;
          bin_d = seed_i;
          rem_d = len_i;
          if (len_i == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            gray_d  = to_gray(seed_i);
            last_d  = (len_i == REM_ONE);
          end
        end
      end

      RUN: begin
        // While ready_i is low, every register holds and the beat is not retracted.
        if (valid_q && ready_i) begin
          if (rem_q == REM_ONE) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bin_d  = bin_step;
            rem_d  = rem_dec;
            gray_d = to_gray(bin_step);
            last_d = (rem_dec == REM_ONE);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. An asynchronous reset aborts any run
  // without producing a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = valid_q;
  assign gray_o  = gray_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
